// File: rtl/fan_pwm_timer_ctrl.sv
// Fan controller: N-level speed FSM, duty ramp, period-latched PWM and auto-off countdown timer.
// Define SOFT_START_EN for the stepped duty ramp; otherwise ramp duty follows the level target.
module fan_pwm_timer_ctrl #(
  parameter int unsigned PWM_BITS      = 10,
  parameter int unsigned N_SPEEDS      = 3,
  parameter int unsigned DUTY_STEP     = 256,
  parameter int unsigned RAMP_DIV      = 1000,
  parameter int unsigned RAMP_STEP     = 32,
  parameter int unsigned TIME_UNIT_CYC = 1000000,
  parameter int unsigned TIME_W        = 5,
  parameter int unsigned TIME_STEP     = 5,
  parameter int unsigned MAX_TIME      = 30
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic                i_btn_up,
  input  logic                i_btn_down,
  input  logic                i_btn_off,
  input  logic                i_btn_time_plus,
  input  logic                i_btn_time_minus,
  input  logic                i_timer_mode,
  output logic                o_pwm,
  output logic [2:0]          o_level,
  output logic [N_SPEEDS:0]   o_led,
  output logic [TIME_W-1:0]   o_time,
  output logic                o_expired
);

  localparam int unsigned UnitW = (TIME_UNIT_CYC > 1) ? $clog2(TIME_UNIT_CYC) : 1;

  if (N_SPEEDS < 1 || N_SPEEDS > 7) begin : g_bad_speeds
    $error("N_SPEEDS must be in 1..7");
  end
  if (N_SPEEDS * DUTY_STEP > (2 ** PWM_BITS) - 1) begin : g_bad_duty
    $error("N_SPEEDS*DUTY_STEP exceeds the PWM range");
  end
  if (MAX_TIME >= 2 ** TIME_W) begin : g_bad_time
    $error("MAX_TIME does not fit in TIME_W bits");
  end
  if (RAMP_DIV < 1 || RAMP_STEP < 1 || TIME_UNIT_CYC < 1) begin : g_bad_div
    $error("RAMP_DIV, RAMP_STEP and TIME_UNIT_CYC must be non-zero");
  end

  typedef enum logic [0:0] {StOff, StRun} state_e;

  state_e              state_q, state_d;
  logic [2:0]          level_q, level_d;
  logic [TIME_W-1:0]   time_q, time_d;
  logic [UnitW-1:0]    unit_q, unit_d;
  logic                expired_q, expired_d;
  logic [PWM_BITS-1:0] ramp_q, ramp_d;
  logic [PWM_BITS-1:0] active_q, active_d;
  logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
  logic                pwm_q, pwm_d;

  logic                time_set;
  logic                cnt_running;
  logic                unit_tick;
  logic                expire;
  logic [PWM_BITS-1:0] target;
  logic [PWM_BITS-1:0] duty_now;
  logic [31:0]         time_sum;
  logic [TIME_W-1:0]   time_up;
  logic [TIME_W-1:0]   time_dn;

  // Simultaneous plus and minus cancel each other out.
  assign time_set    = i_btn_time_plus ^ i_btn_time_minus;
  assign cnt_running = i_timer_mode && (level_q != 3'd0) && (time_q != '0);
  assign unit_tick   = cnt_running && !time_set && (unit_q == UnitW'(TIME_UNIT_CYC - 1));
  assign expire      = unit_tick && !i_btn_off && (time_q == TIME_W'(1));
  assign target      = PWM_BITS'(32'(level_q) * DUTY_STEP);

  assign time_sum = 32'(time_q) + TIME_STEP;
  assign time_up  = (time_sum > MAX_TIME) ? TIME_W'(MAX_TIME) : TIME_W'(time_sum);
  assign time_dn  = (32'(time_q) > TIME_STEP) ? TIME_W'(32'(time_q) - TIME_STEP) : '0;

  always_comb begin
    state_d = state_q;
    level_d = level_q;
    if (i_btn_off || expire) begin
      state_d = StOff;
      level_d = 3'd0;
    end else if (i_btn_up) begin
      state_d = StRun;
      if (32'(level_q) < N_SPEEDS) begin
        level_d = level_q + 3'd1;
      end
    end else if (i_btn_down) begin
      case (state_q)
        StRun: begin
          if (level_q == 3'd1) begin
            state_d = StOff;
            level_d = 3'd0;
          end else begin
            level_d = level_q - 3'd1;
          end
        end
        default: begin
          state_d = StOff;
        end
      endcase
    end
  end

  always_comb begin
    time_d    = time_q;
    unit_d    = '0;
    expired_d = expire;
    if (i_btn_off) begin
      time_d = '0;
    end else if (time_set) begin
      time_d = i_btn_time_plus ? time_up : time_dn;
    end else if (unit_tick) begin
      time_d = time_q - TIME_W'(1);
    end else if (cnt_running) begin
      unit_d = unit_q + UnitW'(1);
    end
  end

`ifdef SOFT_START_EN
  localparam int unsigned DivW = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;

  logic [DivW-1:0] div_q, div_d;
  logic            ramp_tick;

  // Free-running prescaler; commands never restart it.
  assign ramp_tick = (div_q == DivW'(RAMP_DIV - 1));
  assign div_d     = ramp_tick ? '0 : div_q + DivW'(1);

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      div_q <= '0;
    end else begin
      div_q <= div_d;
    end
  end

  always_comb begin
    ramp_d = ramp_q;
    if (i_btn_off) begin
      ramp_d = '0;
    end else if (ramp_tick) begin
      if (ramp_q < target) begin
        ramp_d = (32'(target) - 32'(ramp_q) > RAMP_STEP) ?
                 PWM_BITS'(32'(ramp_q) + RAMP_STEP) : target;
      end else if (ramp_q > target) begin
        ramp_d = (32'(ramp_q) - 32'(target) > RAMP_STEP) ?
                 PWM_BITS'(32'(ramp_q) - RAMP_STEP) : target;
      end
    end
  end
`else
  always_comb begin
    ramp_d = target;
    if (i_btn_off) begin
      ramp_d = '0;
    end
  end
`endif

  // New duty takes effect only at the period start so no pulse is cut short.
  always_comb begin
    duty_now  = (pwm_cnt_q == '0) ? ramp_q : active_q;
    active_d  = duty_now;
    pwm_cnt_d = pwm_cnt_q + PWM_BITS'(1);
    pwm_d     = (pwm_cnt_q < duty_now);
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q   <= StOff;
      level_q   <= 3'd0;
      time_q    <= '0;
      unit_q    <= '0;
      expired_q <= 1'b0;
      ramp_q    <= '0;
      active_q  <= '0;
      pwm_cnt_q <= '0;
      pwm_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      level_q   <= level_d;
      time_q    <= time_d;
      unit_q    <= unit_d;
      expired_q <= expired_d;
      ramp_q    <= ramp_d;
      active_q  <= active_d;
      pwm_cnt_q <= pwm_cnt_d;
      pwm_q     <= pwm_d;
    end
  end

  always_comb begin
    o_led = '0;
    for (int unsigned k = 0; k <= N_SPEEDS; k++) begin
      o_led[k] = (32'(level_q) == k);
    end
  end

  assign o_pwm     = pwm_q;
  assign o_level   = level_q;
  assign o_time    = time_q;
  assign o_expired = expired_q;

endmodule

// File: tb/tb_fan_pwm_timer_ctrl.sv
// Bench for fan_pwm_timer_ctrl: directed table, corner sequences and random pulses vs a cycle model.
module tb_fan_pwm_timer_ctrl;

  localparam int PBITS = 4;
  localparam int NS    = 3;
  localparam int DSTEP = 4;
  localparam int RDIV  = 2;
  localparam int RSTEP = 2;
  localparam int UNIT  = 20;
  localparam int TW    = 5;
  localparam int TSTEP = 5;
  localparam int TMAX  = 30;
  localparam int PER   = 1 << PBITS;
`ifdef SOFT_START_EN
  localparam bit Soft = 1'b1;
`else
  localparam bit Soft = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          up = 0, down = 0, off = 0, tp = 0, tm = 0, mode = 0;
  logic          pwm, expired;
  logic [2:0]    level;
  logic [NS:0]   led;
  logic [TW-1:0] tval;

  int checks = 0;
  int failures = 0;

  // Reference state: values the DUT should show after the next clock edge.
  int m_level, m_time, m_unit, m_ramp, m_div, m_cnt, m_active;
  bit m_pwm, m_exp;

  fan_pwm_timer_ctrl #(
    .PWM_BITS(PBITS), .N_SPEEDS(NS), .DUTY_STEP(DSTEP), .RAMP_DIV(RDIV),
    .RAMP_STEP(RSTEP), .TIME_UNIT_CYC(UNIT), .TIME_W(TW), .TIME_STEP(TSTEP),
    .MAX_TIME(TMAX)
  ) dut (
    .i_clk(clk), .i_reset(rst_n), .i_btn_up(up), .i_btn_down(down), .i_btn_off(off),
    .i_btn_time_plus(tp), .i_btn_time_minus(tm), .i_timer_mode(mode),
    .o_pwm(pwm), .o_level(level), .o_led(led), .o_time(tval), .o_expired(expired)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic up, down, off, tp, tm;
    int   lvl, tim;
  } vec_t;

  vec_t tbl[14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_level = 0; m_time = 0; m_unit = 0; m_ramp = 0; m_div = 0;
    m_cnt = 0; m_active = 0; m_pwm = 0; m_exp = 0;
  endtask

  task automatic model_step(input bit bu, bd, bo, bp, bm, md);
    int nl, nt, nu, nr, duty, tgt;
    bit setp, run, tick;
    setp = bp ^ bm;
    run  = md && m_level != 0 && m_time > 0;
    tick = run && !setp && m_unit == UNIT - 1;
    m_exp = !bo && tick && m_time == 1;
    if (bo) begin nt = 0; nu = 0; end
    else if (setp) begin
      nt = bp ? ((m_time + TSTEP > TMAX) ? TMAX : m_time + TSTEP)
              : ((m_time < TSTEP) ? 0 : m_time - TSTEP);
      nu = 0;
    end else if (tick) begin nt = m_time - 1; nu = 0; end
    else begin nt = m_time; nu = run ? m_unit + 1 : 0; end
    if (bo || m_exp) nl = 0;
    else if (bu) nl = (m_level < NS) ? m_level + 1 : NS;
    else if (bd && m_level > 0) nl = m_level - 1;
    else nl = m_level;
    tgt = m_level * DSTEP;
    if (bo) nr = 0;
    else if (!Soft) nr = tgt;
    else if (m_div == RDIV - 1)
      nr = (m_ramp < tgt) ? ((m_ramp + RSTEP > tgt) ? tgt : m_ramp + RSTEP)
                          : ((m_ramp - RSTEP < tgt) ? tgt : m_ramp - RSTEP);
    else nr = m_ramp;
    duty = (m_cnt == 0) ? m_ramp : m_active;
    m_pwm = m_cnt < duty;
    m_active = duty;
    m_cnt = (m_cnt + 1) % PER;
    m_div = (m_div + 1) % RDIV;
    m_level = nl; m_time = nt; m_unit = nu; m_ramp = nr;
  endtask

  task automatic check_all();
    chk("level", 32'(level), 32'(m_level));
    chk("led", 32'(led), 32'(1) << m_level);
    chk("time", 32'(tval), 32'(m_time));
    chk("expired", 32'(expired), 32'(m_exp));
    chk("pwm", 32'(pwm), 32'(m_pwm));
  endtask

  // Called at a falling edge; applies inputs for one rising edge, then checks.
  task automatic cycle(input logic bu, bd, bo, bp, bm);
    up = bu; down = bd; off = bo; tp = bp; tm = bm;
    model_step(bu, bd, bo, bp, bm, mode);
    @(negedge clk);
    up = 0; down = 0; off = 0; tp = 0; tm = 0;
    check_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0);
  endtask

  initial begin
    int hi, exp_at, exp_cnt;
    bit found;
    tbl[0]  = '{1, 0, 0, 0, 0, 1, 0};
    tbl[1]  = '{1, 1, 0, 0, 0, 2, 0};
    tbl[2]  = '{1, 0, 0, 0, 0, 3, 0};
    tbl[3]  = '{1, 0, 0, 0, 0, 3, 0};
    tbl[4]  = '{0, 1, 0, 0, 0, 2, 0};
    tbl[5]  = '{0, 1, 0, 0, 0, 1, 0};
    tbl[6]  = '{0, 1, 0, 0, 0, 0, 0};
    tbl[7]  = '{0, 1, 0, 0, 0, 0, 0};
    tbl[8]  = '{0, 0, 0, 1, 0, 0, 5};
    tbl[9]  = '{0, 0, 0, 1, 1, 0, 5};
    tbl[10] = '{1, 0, 1, 0, 0, 0, 0};
    tbl[11] = '{0, 0, 0, 1, 0, 0, 5};
    tbl[12] = '{0, 0, 0, 0, 1, 0, 0};
    tbl[13] = '{0, 0, 0, 0, 1, 0, 0};

    model_reset();
    repeat (2) @(negedge clk);
    check_all();
    chk("reset_led", 32'(led), 32'd1);
    rst_n = 1'b1;

    foreach (tbl[i]) begin
      cycle(tbl[i].up, tbl[i].down, tbl[i].off, tbl[i].tp, tbl[i].tm);
      chk($sformatf("tbl%0d_level", i), 32'(level), 32'(tbl[i].lvl));
      chk($sformatf("tbl%0d_time", i), 32'(tval), 32'(tbl[i].tim));
    end

    // Ramp to level 3 and measure the settled duty cycle.
    for (int i = 0; i < 3; i++) cycle(1, 0, 0, 0, 0);
    idle(60);
    hi = 0;
    for (int i = 0; i < PER; i++) begin
      cycle(0, 0, 0, 0, 0);
      hi += int'(pwm);
    end
    chk("settled_high_cycles", 32'(hi), 32'd12);
    cycle(0, 0, 1, 0, 0);
    chk("off_level", 32'(level), 32'd0);
    idle(2 * PER);
    chk("off_pwm", 32'(pwm), 32'd0);

    // Timer setting saturates at both ends.
    for (int i = 1; i <= 7; i++) begin
      cycle(0, 0, 0, 1, 0);
      chk("time_plus", 32'(tval), 32'((i * 5 > TMAX) ? TMAX : i * 5));
    end
    for (int i = 1; i <= 7; i++) begin
      cycle(0, 0, 0, 0, 1);
      chk("time_minus", 32'(tval), 32'((30 - i * 5 < 0) ? 0 : 30 - i * 5));
    end

    // Expiry from 5 units at level 2.
    cycle(1, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0);
    idle(30);
    mode = 1;
    cycle(0, 0, 0, 1, 0);
    exp_at = -1; exp_cnt = 0;
    for (int i = 1; i <= 120; i++) begin
      cycle(0, 0, 0, 0, 0);
      if (expired) begin
        exp_cnt++;
        exp_at = i;
      end
    end
    chk("expire_count", 32'(exp_cnt), 32'd1);
    chk("expire_cycle", 32'(exp_at), 32'd100);
    chk("expire_level", 32'(level), 32'd0);

    // Pause and resume keeps the value and restarts a full unit.
    cycle(1, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0);
    cycle(0, 0, 0, 1, 0);
    idle(40);
    chk("pause_start", 32'(tval), 32'd3);
    mode = 0;
    idle(100);
    chk("pause_hold", 32'(tval), 32'd3);
    mode = 1;
    idle(19);
    chk("resume_19", 32'(tval), 32'd3);
    idle(1);
    chk("resume_20", 32'(tval), 32'd2);
    cycle(0, 1, 0, 0, 0);
    cycle(0, 1, 0, 0, 0);
    idle(60);
    chk("level0_no_count", 32'(tval), 32'd2);

    // Randomised pulses against the model.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 39) == 0) mode = ~mode;
      cycle($urandom_range(0, 7) == 0, $urandom_range(0, 9) == 0, $urandom_range(0, 59) == 0,
            $urandom_range(0, 11) == 0, $urandom_range(0, 13) == 0);
    end

    // Asynchronous reset in the middle of a ramp with the output high.
    cycle(0, 0, 1, 0, 0);
    idle(PER);
    cycle(0, 0, 0, 1, 0);
    for (int i = 0; i < 3; i++) cycle(1, 0, 0, 0, 0);
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      cycle(0, 0, 0, 0, 0);
      found = pwm;
    end
    chk("pwm_high_before_reset", 32'(found), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    chk("reset_led_async", 32'(led), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    idle(30);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
